// File: rtl/mux_2to1_if.sv
// rtl/mux_2to1_if.sv - signal bundle for the 2:1 lane selector
//
// Purpose: groups the selector's data-path signals so one connection carries
// the candidate lanes, the select and all three results.
//   data        2*WIDTH  packed candidate lanes, lane 0 = low half, lane 1 = high half
//   sel         1        lane select, 0 = lane 0, 1 = lane 1
//   out         WIDTH    combinational selected lane
//   out_q       WIDTH    registered selected lane, one-cycle latency
//   sel_changed 1        one-cycle strobe after sel differs from its last sample
// Modports: master drives data/sel and observes results; slave is the selector.
interface mux_2to1_if #(
    parameter int WIDTH = 1
);
    logic [2*WIDTH-1:0] data;
    logic               sel;
    logic [WIDTH-1:0]   out;
    logic [WIDTH-1:0]   out_q;
    logic               sel_changed;

    modport master (
        output data,
        output sel,
        input  out,
        input  out_q,
        input  sel_changed
    );

    modport slave (
        input  data,
        input  sel,
        output out,
        output out_q,
        output sel_changed
    );
endinterface

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - two-lane selector with registered copy and select-change strobe
//
// Purpose: steers one of two WIDTH-bit lanes to a single destination, both
// combinationally (out) and through a register (out_q), and flags any cycle
// in which the select moved (sel_changed).
// Ports:
//   clk  input  single clock, all state updates on the rising edge
//   rst  input  synchronous, active-high reset
//   bus  slave  data/sel in, out/out_q/sel_changed out (see mux_2to1_if)
// Parameters:
//   WIDTH      bit width of each lane
//   RESET_VAL  value loaded into out_q while rst is high
module mux_2to1 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    mux_2to1_if.slave  bus
);

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] lane_sel;
    logic             sel_prev;

    assign lane0 = bus.data[WIDTH-1:0];
    assign lane1 = bus.data[2*WIDTH-1:WIDTH];

    // The conditional operator (rather than if/else) gives the bit-wise merge
    // when sel is unknown: bits where both lanes agree stay known, and an
    // unknown unselected lane never leaks into the result.
    assign lane_sel = bus.sel ? lane1 : lane0;

    assign bus.out = lane_sel;

    // out_q samples the same combinational value driven on out, so a cycle in
    // which data and sel both change captures the new lane's new value.
    // sel_prev clears to 0 on reset, so releasing reset with sel = 1 reports a
    // change on the first active edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_q       <= RESET_VAL;
            sel_prev        <= 1'b0;
            bus.sel_changed <= 1'b0;
        end else begin
            bus.out_q       <= lane_sel;
            bus.sel_changed <= (bus.sel != sel_prev);
            sel_prev        <= bus.sel;
        end
    end

endmodule

// File: tb/tb_mux_2to1.sv
// tb/tb_mux_2to1.sv - self-checking bench for mux_2to1
module tb_mux_2to1;

    localparam int         W  = 1;
    localparam logic [W-1:0] RV = '0;

    logic clk;
    logic rst;

    mux_2to1_if #(.WIDTH(W)) bus ();

    mux_2to1 #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // model state
    logic [W-1:0] m_q;
    logic         m_chg;
    logic         m_prev;
    bit           m_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Selected lane as arithmetic: shift the packed bus right by sel lanes.
    function automatic logic [W-1:0] pick(input logic [2*W-1:0] d, input logic s);
        logic [2*W-1:0] sh;
        sh = s ? (d >> W) : d;
        return sh[W-1:0];
    endfunction

    // Model of the registered outputs, advanced once per rising edge.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_q     = RV;
            m_chg   = 1'b0;
            m_prev  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if ($isunknown(bus.sel)) begin
                m_valid = 1'b0;
            end else begin
                m_chg  = (bus.sel != m_prev);
                m_prev = bus.sel;
                m_q    = pick(bus.data, bus.sel);
            end
        end
    end

    // Continuous compare on the falling edge.
    always @(negedge clk) begin
        if (!$isunknown(bus.sel) && !$isunknown(pick(bus.data, bus.sel)))
            chk("cmp_out", 32'(bus.out), 32'(pick(bus.data, bus.sel)));
        if (m_valid) begin
            chk("cmp_out_q", 32'(bus.out_q), 32'(m_q));
            chk("cmp_sel_changed", 32'(bus.sel_changed), 32'(m_chg));
        end
    end

    // Inputs change 2 time units after each rising edge; checks follow 1 later.
    task automatic drive(input logic [1:0] d, input logic s, input logic r);
        @(posedge clk);
        #2;
        bus.data = d;
        bus.sel  = s;
        rst      = r;
        #1;
    endtask

    initial begin
        logic [1:0] rd;
        logic       rs;
        rst      = 1'b1;
        bus.data = 2'b00;
        bus.sel  = 1'b0;

        // reset held over two edges; out still follows inputs
        drive(2'b00, 1'b0, 1'b1);
        chk("rst_out_a", 32'(bus.out), 32'd0);
        drive(2'b01, 1'b0, 1'b1);
        chk("rst_out_b", 32'(bus.out), 32'd1);
        chk("rst_out_q", 32'(bus.out_q), 32'd0);
        chk("rst_chg", 32'(bus.sel_changed), 32'd0);

        // release with data=10, sel=1
        drive(2'b10, 1'b1, 1'b0);
        chk("rel_out", 32'(bus.out), 32'd1);
        chk("rel_q_pre", 32'(bus.out_q), 32'd0);
        drive(2'b10, 1'b1, 1'b0);
        chk("rel_q", 32'(bus.out_q), 32'd1);
        chk("rel_chg", 32'(bus.sel_changed), 32'd1);
        drive(2'b10, 1'b1, 1'b0);
        chk("rel_chg_clr", 32'(bus.sel_changed), 32'd0);

        // directed combinational vectors
        drive(2'b00, 1'b0, 1'b0); chk("v00s0", 32'(bus.out), 32'd0);
        drive(2'b01, 1'b0, 1'b0); chk("v01s0", 32'(bus.out), 32'd1);
        drive(2'b10, 1'b1, 1'b0); chk("v10s1", 32'(bus.out), 32'd1);
        drive(2'b11, 1'b1, 1'b0); chk("v11s1", 32'(bus.out), 32'd1);
        drive(2'b01, 1'b1, 1'b0); chk("v01s1", 32'(bus.out), 32'd0);

        // toggle sel with data=01; out_q lags out by one cycle
        drive(2'b01, 1'b0, 1'b0);
        drive(2'b01, 1'b1, 1'b0);
        chk("tog_q1", 32'(bus.out_q), 32'd1);
        chk("tog_c1", 32'(bus.sel_changed), 32'd1);
        drive(2'b01, 1'b0, 1'b0);
        chk("tog_q2", 32'(bus.out_q), 32'd0);
        chk("tog_c2", 32'(bus.sel_changed), 32'd1);
        drive(2'b01, 1'b0, 1'b0);
        chk("tog_q3", 32'(bus.out_q), 32'd1);
        chk("tog_c3", 32'(bus.sel_changed), 32'd1);
        drive(2'b01, 1'b0, 1'b0);
        chk("tog_c4", 32'(bus.sel_changed), 32'd0);

        // mid-stream reset while out_q=1
        drive(2'b01, 1'b0, 1'b1);
        chk("mid_q_pre", 32'(bus.out_q), 32'd1);
        chk("mid_out", 32'(bus.out), 32'd1);
        drive(2'b01, 1'b0, 1'b0);
        chk("mid_q_rst", 32'(bus.out_q), 32'd0);
        chk("mid_c_rst", 32'(bus.sel_changed), 32'd0);
        drive(2'b01, 1'b0, 1'b0);
        chk("mid_q_resume", 32'(bus.out_q), 32'd1);
        chk("mid_c_resume", 32'(bus.sel_changed), 32'd0);

        // random pairs
        for (int i = 0; i < 16; i++) begin
            rd = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            drive(rd, rs, 1'b0);
            chk("rand_out", 32'(bus.out), 32'(rs ? rd[1] : rd[0]));
            chk("rand_known", 32'($isunknown(bus.out)), 32'd0);
        end

        // unknown unselected lane does not affect out
        drive(2'bx1, 1'b0, 1'b0);
        chk("x_unsel", 32'(bus.out), 32'd1);
        // unknown select with agreeing lanes gives the common value
        drive(2'b11, 1'bx, 1'b0);
        chk("x_sel", 32'(bus.out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Two-input, one-output selector.
- Drives the selected bit of a 2-bit data bus combinationally on `out`.
- Also provides a registered copy of the selection (`out_q`) for timing-critical consumers, with a single-cycle `sel_changed` strobe.
- Used as a leaf datapath primitive wherever one of two candidate bits must be steered to a single destination.

Parameters:
- WIDTH, 1, bit width of each data lane; `data` is 2*WIDTH bits and `out`/`out_q` are WIDTH bits. Lane 0 is `data[WIDTH-1:0]`; lane 1 is `data[2*WIDTH-1:WIDTH]`.
- RESET_VAL, 0, value loaded into `out_q` on reset (WIDTH bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  2*WIDTH  packed candidate lanes; lane 0 = low half, lane 1 = high half.
- sel  input  1  lane select: 0 picks lane 0, 1 picks lane 1.
- out  output  WIDTH  combinational selected lane.
- out_q  output  WIDTH  registered selected lane, one-cycle latency.
- sel_changed  output  1  registered pulse; high for one cycle after `sel` differs from its previous sampled value.

Behaviour:
- Combinational path:
  - `out = sel ? data[2*WIDTH-1:WIDTH] : data[WIDTH-1:0]`.
  - Zero latency; no dependence on `clk` or `rst`; valid during reset.
  - Settles within the same delta/time step as its inputs (a bench may check 10 time units after applying stimulus).
- `out` is never X/Z when `sel` and the selected lane are known; the unselected lane may be X without affecting `out`.
- When `sel` is X/Z, `out` equals lane 0 bit-wise wherever lane 0 and lane 1 agree. Disagreeing bits are don't-care for synthesis and X in simulation is acceptable.
- Registered path:
  - At each rising `clk`, if `rst` = 1: `out_q` <= RESET_VAL, internal `sel_prev` <= 0, `sel_changed` <= 0.
  - Else: `out_q` <= current combinational `out`; `sel_changed` <= (`sel` != `sel_prev`); `sel_prev` <= `sel`.
- Reset values: `out_q` = RESET_VAL (0 by default), `sel_changed` = 0. `out` has no reset value (purely combinational).
- Reset asserted mid-stream:
  - Registered outputs return to reset values on the next rising edge.
  - `out` keeps tracking inputs.
  - The first cycle after reset release compares against `sel_prev` = 0, so `sel` = 1 at release yields `sel_changed` = 1 one cycle later.
- Simultaneous change of `data` and `sel` in one cycle: `out_q` captures the new lane's new value (no mixed old/new sampling).
- No handshake; the block accepts new inputs every cycle.

Test Plan:
- `data`=2'b00, `sel`=0 -> `out`=0; `data`=2'b01, `sel`=0 -> `out`=1.
- `data`=2'b10, `sel`=1 -> `out`=1; `data`=2'b11, `sel`=1 -> `out`=1; `data`=2'b01, `sel`=1 -> `out`=0.
- 10+ random (`data`, `sel`) pairs, checked after settling -> `out` === (`sel` ? `data[1]` : `data[0]`) every time, with no X.
- Hold `rst`=1 for 2 edges -> `out_q`=0, `sel_changed`=0 while `out` still follows inputs. Release with `data`=2'b10, `sel`=1 -> after next edge `out_q`=1, `sel_changed`=1; after following edge with `sel` unchanged, `sel_changed`=0.
- Toggle `sel` 0->1->0 on successive edges with `data`=2'b01 -> `out_q` sequence 1,0,1 lagging `out` by one cycle, and `sel_changed` high on each cycle after a toggle.
- Assert `rst` mid-sequence while `out_q`=1 -> `out_q`=0 after that edge; normal operation resumes on the first edge after `rst` deasserts.
